// File: rtl/mult_share_arb_pkg.sv
// Shared constants and FSM state encoding for the multiplier-sharing arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_share_arb_pkg;

    localparam int N_DEF    = 32;  // operand/result width
    localparam int Q_DEF    = 16;  // fraction bits of the S-E-M format
    localparam int NREQ_DEF = 4;   // number of requesters

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Round-robin winner search: first set req bit at or above ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is present.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    int j;

    // Scan NREQ positions starting at ptr; the first hit wins and masks the rest.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = PW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Arbitrates NREQ requesters onto one external multiplier; optional grant lock via MULT_SHARE_ARB_LOCK_EN.
// Latency: ack pulses 2 cycles after the IDLE cycle that picks the winner; one product per 3 cycles.
// Backpressure: requesters hold req/operands until ack; losers simply wait for a later IDLE cycle.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int Q    = Q_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*N-1:0] op_a,
    input  logic [NREQ*N-1:0] op_b,
    output logic [N-1:0]      mult1,
    output logic [N-1:0]      mult2,
    input  logic [N-1:0]      out_mult,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic [N-1:0]      result,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [N-1:0]    mult1_q, mult1_d;
    logic [N-1:0]    mult2_q, mult2_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [N-1:0]    result_q, result_d;
    logic            hold_q, hold_d;

    logic [NREQ-1:0] pick_onehot;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] sel_onehot;
    logic [PW-1:0]   sel_idx;
    logic            unused_cfg;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // State and datapath registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            mult1_q  <= '0;
            mult2_q  <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            result_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            mult1_q  <= mult1_d;
            mult2_q  <= mult2_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state logic: IDLE picks and latches operands, MUL captures the product, ACK releases.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        mult1_d    = mult1_q;
        mult2_d    = mult2_q;
        grant_d    = grant_q;
        ack_d      = '0;
        result_d   = result_q;
        hold_d     = hold_q;
        sel_onehot = pick_onehot;
        sel_idx    = pick_idx;
`ifdef MULT_SHARE_ARB_LOCK_EN
        // A locked previous owner that is still requesting bypasses the round-robin search.
        if (hold_q && req[win_q]) begin
            sel_idx             = win_q;
            sel_onehot          = '0;
            sel_onehot[win_q]   = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                hold_d = 1'b0;
                if (pick_valid) begin
                    state_d = MUL;
                    win_d   = sel_idx;
                    mult1_d = op_a[int'(sel_idx)*N +: N];
                    mult2_d = op_b[int'(sel_idx)*N +: N];
                    grant_d = sel_onehot;
                end
            end
            MUL: begin
                state_d  = ACK;
                result_d = out_mult;
                ack_d    = grant_q;
            end
            ACK: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
`ifdef MULT_SHARE_ARB_LOCK_EN
                if (lock[win_q]) begin
                    ptr_d  = ptr_q;
                    hold_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

`ifdef MULT_SHARE_ARB_LOCK_EN
    assign unused_cfg = ^{32'(Q)};
`else
    // Without the lock feature the lock port and hold flop carry no function.
    assign unused_cfg = ^{lock, hold_q, 32'(Q)};
`endif

    assign mult1  = mult1_q;
    assign mult2  = mult2_q;
    assign grant  = grant_q;
    assign ack    = ack_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

    localparam int N    = 32;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*N-1:0] op_a;
    logic [NREQ*N-1:0] op_b;
    logic [N-1:0]      mult1;
    logic [N-1:0]      mult2;
    logic [N-1:0]      out_mult;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic [N-1:0]      result;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference Q16.16 sign-magnitude multiplier standing in for the external qmult.
    function automatic logic [31:0] qm(input logic [31:0] a, input logic [31:0] b);
        logic [61:0] p;
        p = 62'(a[30:0]) * 62'(b[30:0]);
        return {a[31] ^ b[31], p[46:16]};
    endfunction

    assign out_mult = qm(mult1, mult2);

    mult_share_arb #(.N(32), .Q(16), .NREQ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .op_a     (op_a),
        .op_b     (op_b),
        .mult1    (mult1),
        .mult2    (mult2),
        .out_mult (out_mult),
        .grant    (grant),
        .ack      (ack),
        .result   (result),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic onehot0(input logic [NREQ-1:0] v);
        return (v & (v - 4'd1)) == 4'd0;
    endfunction

    logic [NREQ-1:0] exp_ack;
    logic [NREQ-1:0] seq [6];

    initial begin
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        op_a = '0;
        op_b = '0;
        step();
        step();
        chk("rst_grant",  64'(grant),  64'(0));
        chk("rst_ack",    64'(ack),    64'(0));
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_mult1",  64'(mult1),  64'(0));
        chk("rst_mult2",  64'(mult2),  64'(0));
        chk("rst_result", 64'(result), 64'(0));
        rst = 1'b0;
        step();

        // Single request, 2.0 * 3.0
        op_a[0*N +: N] = 32'h0002_0000;
        op_b[0*N +: N] = 32'h0003_0000;
        req = 4'b0001;
        step();
        chk("t1_grant", 64'(grant), 64'(4'b0001));
        chk("t1_busy",  64'(busy),  64'(1));
        chk("t1_mult1", 64'(mult1), 64'(32'h0002_0000));
        chk("t1_mult2", 64'(mult2), 64'(32'h0003_0000));
        chk("t1_ack0",  64'(ack),   64'(0));
        step();
        chk("t1_ack",    64'(ack),    64'(4'b0001));
        chk("t1_result", 64'(result), 64'(32'h0006_0000));
        req = 4'b0000;
        step();
        chk("t1_ack_off",   64'(ack),   64'(0));
        chk("t1_grant_off", 64'(grant), 64'(0));
        chk("t1_idle",      64'(busy),  64'(0));

        // Signed operand, -1.5 * 2.0
        op_a[2*N +: N] = 32'h8001_8000;
        op_b[2*N +: N] = 32'h0002_0000;
        req = 4'b0100;
        step();
        chk("t2_grant", 64'(grant), 64'(4'b0100));
        step();
        chk("t2_ack",    64'(ack),    64'(4'b0100));
        chk("t2_result", 64'(result), 64'(32'h8003_0000));
        req = 4'b0000;
        step();
        chk("t2_idle", 64'(busy), 64'(0));

        // All requesters held, starting from ptr=0 after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*N +: N] = 32'((i + 1) << 16);
            op_b[i*N +: N] = 32'h0001_0000;
        end
        req = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            step();
            exp_ack = (c % 3 == 2) ? 4'(1 << (((c - 2) / 3) % 4)) : 4'b0000;
            chk("t3_ack", 64'(ack), 64'(exp_ack));
            chk("t3_grant_1hot", 64'(onehot0(grant)), 64'(1));
            if (c % 3 == 2)
                chk("t3_result", 64'(result), 64'(((((c - 2) / 3) % 4) + 1) << 16));
        end
        req = 4'b0000;
        step();
        chk("t3_idle", 64'(busy), 64'(0));

        // Reset during MUL aborts the transaction; a held request restarts cleanly
        op_a[1*N +: N] = 32'h0005_0000;
        op_b[1*N +: N] = 32'h0002_0000;
        req = 4'b0010;
        step();
        chk("t4_grant", 64'(grant), 64'(4'b0010));
        rst = 1'b1;
        step();
        chk("t4_rst_grant", 64'(grant), 64'(0));
        chk("t4_rst_mult1", 64'(mult1), 64'(0));
        chk("t4_rst_ack",   64'(ack),   64'(0));
        chk("t4_rst_busy",  64'(busy),  64'(0));
        rst = 1'b0;
        step();
        chk("t4_regrant", 64'(grant), 64'(4'b0010));
        chk("t4_no_ack",  64'(ack),   64'(0));
        step();
        chk("t4_ack",    64'(ack),    64'(4'b0010));
        chk("t4_result", 64'(result), 64'(32'h000A_0000));
        req = 4'b0000;
        step();
        chk("t4_idle", 64'(busy), 64'(0));

        // Two requesters with lock[0] raised, then released before the fifth transaction
`ifdef MULT_SHARE_ARB_LOCK_EN
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        op_a[0*N +: N] = 32'h0002_0000;
        op_b[0*N +: N] = 32'h0003_0000;
        req  = 4'b0011;
        lock = 4'b0001;
        for (int t = 0; t < 6; t++) begin
            if (t == 4)
                lock = 4'b0000;
            step();
            chk("t5_grant", 64'(grant), 64'(seq[t]));
            step();
            chk("t5_ack",    64'(ack),    64'(seq[t]));
            chk("t5_result", 64'(result),
                64'((seq[t] == 4'b0001) ? 32'h0006_0000 : 32'h000A_0000));
            step();
            chk("t5_ack_off", 64'(ack), 64'(0));
        end
        req = 4'b0000;
        step();
        chk("t5_idle", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
